// File: rtl/fdiv_norm_round_pack_if.sv
// Handshake and data bundle between the divider pipeline and the FP divide
// normalize/round/pack stage.
interface fdiv_norm_round_pack_if;
  logic        fdiv;
  logic [31:0] fa;
  logic [31:0] fb;
  logic [1:0]  rm;
  logic [31:0] q;
  logic        q_valid;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        out_valid;
  logic        busy;

  modport master (
    output fdiv, fa, fb, rm, q, q_valid,
    input  result, flags, out_valid, busy
  );

  modport slave (
    input  fdiv, fa, fb, rm, q, q_valid,
    output result, flags, out_valid, busy
  );
endinterface

// File: rtl/fdiv_norm_round_pack.sv
// Back end of the single-precision divider: captures operand sign/exponent/class,
// normalizes and rounds the mantissa quotient, and packs the IEEE result + flags.
module fdiv_norm_round_pack #(
  parameter int BIAS = 127,
  parameter int QW   = 32
) (
  input logic                   clock,
  input logic                   resetn,
  fdiv_norm_round_pack_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT_Q = 3'd1;
  localparam logic [2:0] ST_NORM   = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_OUT    = 3'd4;

  // Returns {special, flags[4:0], result[31:0]}; special=0 means divide normally.
  function automatic logic [37:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [37:0] r;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r = {1'b1, 5'b10000, 32'h7FC00000};
    end else if (a_inf) begin
      r = {1'b1, 5'b00000, s, 31'h7F800000};
    end else if (b_zero) begin
      r = {1'b1, 5'b01000, s, 31'h7F800000};
    end else if (a_zero || b_inf) begin
      r = {1'b1, 5'b00000, s, 31'h00000000};
    end else begin
      r = {1'b0, 5'b00000, 32'h00000000};
    end
    return r;
  endfunction

  logic [2:0]        state_r, state_nxt_s;
  logic              s_r;
  logic [1:0]        rm_r;
  logic signed [9:0] e_r;
  logic              special_r;
  logic [31:0]       sp_result_r;
  logic [4:0]        sp_flags_r;
  logic [QW-1:0]     q_r;
  logic [23:0]       m_r;
  logic              g_r, st_r;

  logic [37:0]       class_s;
  logic [9:0]        e_start_s;
  logic              inc_s, to_inf_s, carry_s;
  logic [22:0]       frac_s;
  logic signed [9:0] e_rnd_s;
  logic [31:0]       pack_result_s;
  logic [4:0]        pack_flags_s;

  logic [31:0]       result_r;
  logic [4:0]        flags_r;
  logic              out_valid_r;
  logic              busy_r;

  assign class_s   = classify(bus.fa, bus.fb);
  assign e_start_s = {2'b00, bus.fa[30:23]} - {2'b00, bus.fb[30:23]} + 10'(BIAS);

  // Next-state logic; special operands use the ROUND slot as a pack cycle so
  // they report two cycles after fdiv.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.fdiv) begin
          state_nxt_s = class_s[37] ? ST_ROUND : ST_WAIT_Q;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_Q: begin
        if (bus.q_valid) begin
          state_nxt_s = ST_NORM;
        end else begin
          state_nxt_s = ST_WAIT_Q;
        end
      end
      ST_NORM:  state_nxt_s = ST_ROUND;
      ST_ROUND: state_nxt_s = ST_OUT;
      ST_OUT:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Rounding increment and overflow direction from the latched rounding mode.
  always_comb begin
    inc_s    = 1'b0;
    to_inf_s = 1'b0;
    case (rm_r)
      2'b00: begin inc_s = g_r & (st_r | m_r[0]);  to_inf_s = 1'b1;  end
      2'b01: begin inc_s = 1'b0;                   to_inf_s = 1'b0;  end
      2'b10: begin inc_s = s_r & (g_r | st_r);     to_inf_s = s_r;   end
      2'b11: begin inc_s = ~s_r & (g_r | st_r);    to_inf_s = ~s_r;  end
      default: begin inc_s = 1'b0;                 to_inf_s = 1'b0;  end
    endcase
  end

  // All-ones mantissa plus one wraps the fraction to zero, which is exactly 1.0 of the next binade.
  assign carry_s = inc_s & (m_r == 24'hFFFFFF);
  assign frac_s  = m_r[22:0] + {22'd0, inc_s};

  // Final exponent and range-checked packing.
  always_comb begin
    pack_result_s = 32'h00000000;
    pack_flags_s  = 5'b00000;
    if (carry_s) begin
      e_rnd_s = e_r + 10'sd1;
    end else begin
      e_rnd_s = e_r;
    end
    if (special_r) begin
      pack_result_s = sp_result_r;
      pack_flags_s  = sp_flags_r;
    end else if (e_rnd_s >= 10'sd255) begin
      pack_flags_s  = 5'b00101;
      pack_result_s = to_inf_s ? {s_r, 31'h7F800000} : {s_r, 31'h7F7FFFFF};
    end else if (e_rnd_s <= 10'sd0) begin
      pack_flags_s  = 5'b00011;
      pack_result_s = {s_r, 31'h00000000};
    end else begin
      pack_flags_s  = {4'b0000, g_r | st_r};
      pack_result_s = {s_r, e_rnd_s[7:0], frac_s};
    end
  end

  // Operand capture, quotient capture and normalization.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      s_r         <= 1'b0;
      rm_r        <= 2'b00;
      e_r         <= 10'sd0;
      special_r   <= 1'b0;
      sp_result_r <= 32'h00000000;
      sp_flags_r  <= 5'b00000;
      q_r         <= '0;
      m_r         <= 24'd0;
      g_r         <= 1'b0;
      st_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && bus.fdiv) begin
        s_r         <= bus.fa[31] ^ bus.fb[31];
        rm_r        <= bus.rm;
        e_r         <= $signed(e_start_s);
        special_r   <= class_s[37];
        sp_flags_r  <= class_s[36:32];
        sp_result_r <= class_s[31:0];
      end
      if (state_r == ST_WAIT_Q && bus.q_valid) begin
        q_r <= bus.q;
      end
      if (state_r == ST_NORM) begin
        if (q_r[QW-1]) begin
          m_r  <= q_r[QW-1 -: 24];
          g_r  <= q_r[QW-25];
          st_r <= |q_r[QW-26:0];
        end else begin
          m_r  <= q_r[QW-2 -: 24];
          g_r  <= q_r[QW-26];
          st_r <= |q_r[QW-27:0];
          e_r  <= e_r - 10'sd1;
        end
      end
    end
  end

  // Registered outputs: result/flags load as OUT is entered and hold until the next one.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      result_r    <= 32'h00000000;
      flags_r     <= 5'b00000;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= (state_r == ST_ROUND);
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (state_r == ST_ROUND) begin
        result_r <= pack_result_s;
        flags_r  <= pack_flags_s;
      end
    end
  end

  assign bus.result    = result_r;
  assign bus.flags     = flags_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_fdiv_norm_round_pack.sv
// Directed vector bench for fdiv_norm_round_pack: table of hand-computed cases
// plus hand-written sequences for stray pulses and mid-operation reset.
module tb_fdiv_norm_round_pack;

  logic clock = 1'b0;
  logic resetn;

  fdiv_norm_round_pack_if bus ();

  fdiv_norm_round_pack dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] fa;
    logic [31:0] fb;
    logic [1:0]  rm;
    logic [31:0] q;
    logic        sp;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
    bus.fdiv = 1'b1;
    bus.fa   = a;
    bus.fb   = b;
    bus.rm   = m;
    step();
    bus.fdiv = 1'b0;
  endtask

  task automatic pulse_q(input logic [31:0] qv);
    bus.q_valid = 1'b1;
    bus.q       = qv;
    step();
    bus.q_valid = 1'b0;
  endtask

  // Cycles from the current sample point (counted from 1) until out_valid; 0 on timeout.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      if (bus.out_valid === 1'b1) lat = k;
      else step();
    end
  endtask

  task automatic count_out(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      if (bus.out_valid === 1'b1) n++;
      step();
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat;
    start(v.fa, v.fb, v.rm);
    if (!v.sp) begin
      step();
      pulse_q(v.q);
    end
    wait_out(lat);
    check({tag, " latency"}, 32'(lat), v.sp ? 32'd2 : 32'd3);
    check({tag, " result"}, bus.result, v.res);
    check({tag, " flags"}, {27'd0, bus.flags}, {27'd0, v.flg});
    check({tag, " busy@out"}, {31'd0, bus.busy}, 32'd1);
    step();
    check({tag, " out_valid pulse"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " busy after"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " result"}, bus.result, 32'h00000000);
    check({tag, " flags"}, {27'd0, bus.flags}, 32'd0);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    // fa, fb, rm, q, special, result, flags {inv,dz,ovf,unf,inx}
    vecs.push_back(vec_t'{32'h40C00000, 32'h40400000, 2'b00, 32'h80000000, 1'b0, 32'h40000000, 5'b00000});
    vecs.push_back(vec_t'{32'h3F800000, 32'h40400000, 2'b00, 32'h55555555, 1'b0, 32'h3EAAAAAB, 5'b00001});
    vecs.push_back(vec_t'{32'h3F800000, 32'h40400000, 2'b01, 32'h55555555, 1'b0, 32'h3EAAAAAA, 5'b00001});
    vecs.push_back(vec_t'{32'hBF800000, 32'h40400000, 2'b10, 32'h55555555, 1'b0, 32'hBEAAAAAB, 5'b00001});
    vecs.push_back(vec_t'{32'hBF800000, 32'h40400000, 2'b11, 32'h55555555, 1'b0, 32'hBEAAAAAA, 5'b00001});
    vecs.push_back(vec_t'{32'h3F800000, 32'h3F800000, 2'b00, 32'hFFFFFF80, 1'b0, 32'h40000000, 5'b00001});
    vecs.push_back(vec_t'{32'h7F000000, 32'h00800000, 2'b00, 32'h80000000, 1'b0, 32'h7F800000, 5'b00101});
    vecs.push_back(vec_t'{32'h7F000000, 32'h00800000, 2'b01, 32'h80000000, 1'b0, 32'h7F7FFFFF, 5'b00101});
    vecs.push_back(vec_t'{32'h7F000000, 32'h00800000, 2'b10, 32'h80000000, 1'b0, 32'h7F7FFFFF, 5'b00101});
    vecs.push_back(vec_t'{32'hFF000000, 32'h00800000, 2'b10, 32'h80000000, 1'b0, 32'hFF800000, 5'b00101});
    vecs.push_back(vec_t'{32'h7F000000, 32'h3F000000, 2'b00, 32'h80000000, 1'b0, 32'h7F800000, 5'b00101});
    vecs.push_back(vec_t'{32'h00800000, 32'h7F000000, 2'b00, 32'h80000000, 1'b0, 32'h00000000, 5'b00011});
    vecs.push_back(vec_t'{32'h00800000, 32'h3F800000, 2'b00, 32'h80000000, 1'b0, 32'h00800000, 5'b00000});
    vecs.push_back(vec_t'{32'h00800000, 32'h3F800000, 2'b00, 32'h7FFFFFFF, 1'b0, 32'h00800000, 5'b00001});
    vecs.push_back(vec_t'{32'h00800000, 32'h3F800000, 2'b01, 32'h7FFFFFFF, 1'b0, 32'h00000000, 5'b00011});
    vecs.push_back(vec_t'{32'h3F800000, 32'h00000000, 2'b00, 32'h00000000, 1'b1, 32'h7F800000, 5'b01000});
    vecs.push_back(vec_t'{32'h00000000, 32'h00000000, 2'b00, 32'h00000000, 1'b1, 32'h7FC00000, 5'b10000});
    vecs.push_back(vec_t'{32'h7F800000, 32'h40000000, 2'b00, 32'h00000000, 1'b1, 32'h7F800000, 5'b00000});
    vecs.push_back(vec_t'{32'hBF800000, 32'h7F800000, 2'b00, 32'h00000000, 1'b1, 32'h80000000, 5'b00000});
    vecs.push_back(vec_t'{32'h7F800001, 32'h3F800000, 2'b00, 32'h00000000, 1'b1, 32'h7FC00000, 5'b10000});
    vecs.push_back(vec_t'{32'h7F800000, 32'hFF800000, 2'b00, 32'h00000000, 1'b1, 32'h7FC00000, 5'b10000});
    vecs.push_back(vec_t'{32'h00400000, 32'h3F800000, 2'b00, 32'h00000000, 1'b1, 32'h00000000, 5'b00000});

    bus.fdiv    = 1'b0;
    bus.fa      = 32'h00000000;
    bus.fb      = 32'h00000000;
    bus.rm      = 2'b00;
    bus.q       = 32'h00000000;
    bus.q_valid = 1'b0;
    resetn      = 1'b0;
    step();
    step();
    check_zero("reset");
    resetn = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Special case, then a stray quotient from the divider must not produce output.
    start(32'h3F800000, 32'h00000000, 2'b00);
    wait_out(lat);
    check("stray latency", 32'(lat), 32'd2);
    check("stray result", bus.result, 32'h7F800000);
    step();
    pulse_q(32'h80000000);
    count_out(6, n);
    check("stray q_valid out_valid count", 32'(n), 32'd0);
    check("stray result held", bus.result, 32'h7F800000);

    // A second fdiv while waiting for the quotient is ignored.
    start(32'h3F800000, 32'h40400000, 2'b00);
    step();
    start(32'h00000000, 32'h00000000, 2'b00);
    pulse_q(32'h55555555);
    wait_out(lat);
    check("fdiv-in-wait latency", 32'(lat), 32'd3);
    check("fdiv-in-wait result", bus.result, 32'h3EAAAAAB);
    check("fdiv-in-wait flags", {27'd0, bus.flags}, 32'd1);
    step();

    // Reset while in WAIT_Q.
    start(32'h40C00000, 32'h40400000, 2'b00);
    step();
    check("wait busy before reset", {31'd0, bus.busy}, 32'd1);
    resetn = 1'b0;
    #1;
    check_zero("reset in WAIT_Q");
    step();
    resetn = 1'b1;
    pulse_q(32'h80000000);
    count_out(6, n);
    check("post-reset WAIT_Q out_valid count", 32'(n), 32'd0);

    // Reset while in ROUND.
    apply(vecs[1], "pre-round");
    start(32'h40C00000, 32'h40400000, 2'b00);
    step();
    pulse_q(32'h80000000);
    step();
    resetn = 1'b0;
    #1;
    check_zero("reset in ROUND");
    step();
    resetn = 1'b1;
    count_out(6, n);
    check("post-reset ROUND out_valid count", 32'(n), 32'd0);

    apply(vecs[0], "after-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
